mul_seq_unit: RTL
=================

Name: mul_seq_unit

Overview:
- Iterative multi-cycle multiplier for the multicycle ARM datapath.
- Consumes the controller's ALUControl multiply encodings (MUL, UMULL, SMULL) and operands A/B from the register-read stage.
- Returns a 64-bit product plus N/Z flags.
- Holds busy high so the main FSM stalls in its execute state until done pulses.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  3'b100 MUL, 3'b101 UMULL, 3'b110 SMULL; other codes are invalid.
- a  input  WIDTH  multiplicand (Rn).
- b  input  WIDTH  multiplier (Rm).
- busy  output  1  high from the cycle after start is accepted until the DONE state is reached.
- done  output  1  one-cycle pulse; result and flags are valid.
- result_lo  output  WIDTH  product bits [WIDTH-1:0].
- result_hi  output  WIDTH  product bits [2*WIDTH-1:WIDTH]; zero for MUL.
- flag_n  output  1  N flag for this result.
- flag_z  output  1  Z flag for this result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; busy=0, done=0.
  - result_lo=0, result_hi=0, flag_n=0, flag_z=0.
  - Internal accumulator, counter and sign registers cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start=1 and op is valid: latch op and operands, then go to CALC.
  - For SMULL, latch |a|, |b| and neg = a[WIDTH-1]^b[WIDTH-1].
  - For MUL/UMULL, latch raw operands and neg=0.
  - start=0 or invalid op: stay in IDLE; outputs unchanged.
- CALC, WIDTH cycles (counter WIDTH-1 down to 0):
  - Radix-2 shift-add: if multiplier LSB=1, add the multiplicand to the upper accumulator half.
  - Shift the {carry, accumulator} right by 1.
  - Carry-out of the add is kept, so there is no loss at 2*WIDTH bits.
  - When counter=0, go to FIX.
- FIX, 1 cycle:
  - If neg=1, two's-complement the 64-bit product.
  - For MUL, force result_hi=0.
  - Go to DONE.
- DONE, 1 cycle:
  - Register outputs: done=1, busy=0.
  - Go to IDLE.
  - start is ignored in this cycle.
- Latency:
  - start accepted at edge 0; done is high in the cycle after edge WIDTH+2.
  - WIDTH=32 gives 34 cycles.
- Flags:
  - MUL: flag_n=result_lo[WIDTH-1], flag_z=(result_lo==0).
  - UMULL/SMULL: flag_n=result_hi[WIDTH-1], flag_z=(full 64 bits==0).
- Outputs hold their last result until the next DONE; they are not cleared on start.
- start while busy=1 is ignored; there is no queueing and the operands in flight are unaffected.
- Operand inputs may change after the start cycle without affecting the result.
- Reset asserted mid-CALC/FIX aborts the operation: busy=0, done never pulses, outputs are zeroed.
- SMULL with a=b=most-negative value: |x| computed as unsigned WIDTH bits (2^31), product 2^62, positive. Correct.
- Operand of 0: the full CALC is still executed unless EARLY_TERM_EN is defined.

Optional Feature:
- Macro: MUL_SEQ_EARLY_TERM_EN.
- Defined:
  - In CALC, if the remaining unshifted multiplier bits are all 0, apply the remaining shift in one step and go to FIX next cycle.
  - Minimum latency is 3 cycles (b=0 or b=1); done/busy handshake is unchanged.
  - Results are identical to the non-early path.
- Undefined:
  - Fixed WIDTH+2 latency; no early-exit logic is synthesised.

Test Plan:
- Reset: pulse reset=0 mid-idle and mid-CALC (cycle 10) -> busy=0, done=0, result_lo/hi=0 immediately; no done pulse follows.
- MUL: a=7, b=6, op=100 -> done at 34 cycles; result_lo=42, result_hi=0, N=0, Z=0.
- UMULL: a=0xFFFFFFFF, b=0xFFFFFFFF, op=101 -> {hi,lo}=0xFFFFFFFE_00000001, N=1, Z=0.
- SMULL: a=-3 (0xFFFFFFFD), b=5, op=110 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1, N=1.
- SMULL: a=b=0x80000000 -> 0x40000000_00000000, N=0.
- Handshake: start=1 held during busy, plus start with op=3'b111 in IDLE -> exactly one done per accepted start; invalid op never raises busy.
- Zero operand: a=0, b=0x12345678, op=101 -> result 0, Z=1.
  - With MUL_SEQ_EARLY_TERM_EN and b=1: done within 3 cycles of start.

Source files
------------

// File: rtl/mul_seq_unit_if.sv
// Request/response bundle between the multicycle controller and mul_seq_unit.
// The controller side uses the master modport; the multiplier uses slave.
interface mul_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flag_n, flag_z
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flag_n, flag_z
    );
endinterface

// File: rtl/mul_seq_unit.sv
// Iterative radix-2 shift-add multiplier (MUL/UMULL/SMULL) with N/Z flags.
// Define MUL_SEQ_EARLY_TERM_EN to leave CALC once the remaining multiplier bits are zero.
module mul_seq_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    mul_seq_unit_if.slave   bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntFirst = CntW'(WIDTH - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [2:0] OpMul   = 3'b100;
    localparam logic [2:0] OpUmull = 3'b101;
    localparam logic [2:0] OpSmull = 3'b110;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 neg_q, neg_d;
    logic [2:0]           op_q, op_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     res_lo_q, res_lo_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d;
    logic                 flag_n_q, flag_n_d;
    logic                 flag_z_q, flag_z_d;

    logic                 op_valid;
    logic                 start_ok;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   prod;
    logic                 calc_last;

    assign op_valid = (bus.op == OpMul) || (bus.op == OpUmull) || (bus.op == OpSmull);
    assign start_ok = bus.start && op_valid;
    assign a_abs    = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_abs    = bus.b[WIDTH-1] ? -bus.b : bus.b;

    // Keep the carry so the upper half never overflows before the shift.
    assign sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign step = {sum, acc_q[WIDTH-1:1]};

`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [WIDTH-1:0] rest_mask;
    logic             rest_zero;

    // Multiplier bits still unprocessed after this step sit in acc_q[cnt_q:1].
    assign rest_mask = ~({WIDTH{1'b1}} << cnt_q);
    assign rest_zero = ((acc_q[WIDTH-1:0] >> 1) & rest_mask) == '0;
    assign calc_last = (cnt_q == '0) || rest_zero;
`else
    assign calc_last = (cnt_q == '0);
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_ok) state_d = StCalc;
            StCalc:  if (calc_last) state_d = StFix;
            StFix:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        op_d     = op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        flag_n_d = flag_n_q;
        flag_z_d = flag_z_q;
        prod     = acc_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    op_d   = bus.op;
                    cnt_d  = CntFirst;
                    busy_d = 1'b1;
                    if (bus.op == OpSmull) begin
                        mcand_d = a_abs;
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                        neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    end else begin
                        mcand_d = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                        neg_d   = 1'b0;
                    end
                end
            end
            StCalc: begin
                acc_d = step;
`ifdef MUL_SEQ_EARLY_TERM_EN
                if (rest_zero) acc_d = step >> cnt_q;
`endif
                cnt_d = cnt_q - CntOne;
            end
            StFix: begin
                prod = neg_q ? -acc_q : acc_q;
                if (op_q == OpMul) prod[2*WIDTH-1:WIDTH] = '0;
                acc_d  = prod;
                busy_d = 1'b0;
            end
            StDone: begin
                done_d   = 1'b1;
                res_lo_d = acc_q[WIDTH-1:0];
                res_hi_d = acc_q[2*WIDTH-1:WIDTH];
                if (op_q == OpMul) begin
                    flag_n_d = acc_q[WIDTH-1];
                    flag_z_d = (acc_q[WIDTH-1:0] == '0);
                end else begin
                    flag_n_d = acc_q[2*WIDTH-1];
                    flag_z_d = (acc_q == '0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            flag_n_q <= flag_n_d;
            flag_z_q <= flag_z_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.result_lo = res_lo_q;
    assign bus.result_hi = res_hi_q;
    assign bus.flag_n    = flag_n_q;
    assign bus.flag_z    = flag_z_q;
endmodule
